// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver: filtered clock, 11-bit frame FSM and Hack key-code decoder.
// Optional macro KBD_SHIFT_EN: tracks shift for lower-case letters and shifted digit symbols.
module ps2_keyboard #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FILTER_LEN  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        key_valid,
    output logic        frame_err
);
    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int FL_W        = $clog2(FILTER_LEN + 1);
`ifdef KBD_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    function automatic logic [15:0] map_code(input logic ext, input logic [7:0] b, input logic shift);
        logic [7:0] c;
        logic       sh;
        sh = SHIFT_EN && shift;
        c  = 8'd0;
        if (ext) begin
            case (b)
                8'h6B: c = 8'd130;  8'h75: c = 8'd131;  8'h74: c = 8'd132;  8'h72: c = 8'd133;
                8'h6C: c = 8'd134;  8'h69: c = 8'd135;  8'h7D: c = 8'd136;  8'h7A: c = 8'd137;
                8'h70: c = 8'd138;  8'h71: c = 8'd139;
                default: c = 8'd0;
            endcase
        end else begin
            case (b)
                8'h1C: c = 8'd65;  8'h32: c = 8'd66;  8'h21: c = 8'd67;  8'h23: c = 8'd68;
                8'h24: c = 8'd69;  8'h2B: c = 8'd70;  8'h34: c = 8'd71;  8'h33: c = 8'd72;
                8'h43: c = 8'd73;  8'h3B: c = 8'd74;  8'h42: c = 8'd75;  8'h4B: c = 8'd76;
                8'h3A: c = 8'd77;  8'h31: c = 8'd78;  8'h44: c = 8'd79;  8'h4D: c = 8'd80;
                8'h15: c = 8'd81;  8'h2D: c = 8'd82;  8'h1B: c = 8'd83;  8'h2C: c = 8'd84;
                8'h3C: c = 8'd85;  8'h2A: c = 8'd86;  8'h1D: c = 8'd87;  8'h22: c = 8'd88;
                8'h35: c = 8'd89;  8'h1A: c = 8'd90;
                8'h45: c = sh ? 8'd41 : 8'd48;  8'h16: c = sh ? 8'd33 : 8'd49;
                8'h1E: c = sh ? 8'd64 : 8'd50;  8'h26: c = sh ? 8'd35 : 8'd51;
                8'h25: c = sh ? 8'd36 : 8'd52;  8'h2E: c = sh ? 8'd37 : 8'd53;
                8'h36: c = sh ? 8'd94 : 8'd54;  8'h3D: c = sh ? 8'd38 : 8'd55;
                8'h3E: c = sh ? 8'd42 : 8'd56;  8'h46: c = sh ? 8'd40 : 8'd57;
                8'h29: c = 8'd32;   8'h5A: c = 8'd128;  8'h66: c = 8'd129;  8'h76: c = 8'd140;
                8'h05: c = 8'd141;  8'h06: c = 8'd142;  8'h04: c = 8'd143;  8'h0C: c = 8'd144;
                8'h03: c = 8'd145;  8'h0B: c = 8'd146;  8'h83: c = 8'd147;  8'h0A: c = 8'd148;
                8'h01: c = 8'd149;  8'h09: c = 8'd150;  8'h78: c = 8'd151;  8'h07: c = 8'd152;
                default: c = 8'd0;
            endcase
            if (SHIFT_EN && !shift && c >= 8'd65 && c <= 8'd90)
                c = c + 8'd32;
        end
        return {8'd0, c};
    endfunction

    // Input conditioning: two-flop synchronisers, then a level filter on the clock line
    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_filt_q;
    logic [FL_W-1:0] filt_cnt_q;
    logic            se, din;

    assign din = data_sync_q[1];
    assign se  = clk_filt_q && !clk_sync_q[1] && (filt_cnt_q == FL_W'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
                clk_filt_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FL_W'(1);
            end
        end
    end

    // Frame FSM; parity faults are held until the stop bit so a frame yields one error strobe
    state_e          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      sr_q;
    logic            par_err_q, byte_rdy_q, frame_err_q;
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 8'd0;
            par_err_q   <= 1'b0;
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (se) begin
                to_cnt_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        if (!din) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        sr_q      <= {din, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= PARITY;
                    end
                    PARITY: begin
                        par_err_q <= ~(^{sr_q, din});
                        state_q   <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (din && !par_err_q)
                            byte_rdy_q <= 1'b1;
                        else
                            frame_err_q <= 1'b1;
                    end
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    state_q     <= IDLE;
                    frame_err_q <= 1'b1;
                    to_cnt_q    <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end
        end
    end

    // Scancode decoder
    logic        ext_q, brk_q, is_shift, shift_flag;
    logic [15:0] key_q, key_d, code_now;
    logic        key_valid_q;

`ifdef KBD_SHIFT_EN
    logic shift_flag_q;
    assign is_shift   = !ext_q && (sr_q == 8'h12 || sr_q == 8'h59);
    assign shift_flag = shift_flag_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shift_flag_q <= 1'b0;
        else if (byte_rdy_q && is_shift)
            shift_flag_q <= !brk_q;
    end
`else
    assign is_shift   = 1'b0;
    assign shift_flag = 1'b0;
`endif

    assign code_now = map_code(ext_q, sr_q, shift_flag);

    // A break matches either shift variant so a key held across a shift change still releases
    always_comb begin
        key_d = key_q;
        if (brk_q) begin
            if (map_code(ext_q, sr_q, 1'b0) == key_q || map_code(ext_q, sr_q, 1'b1) == key_q)
                key_d = 16'd0;
        end else if (code_now != 16'd0) begin
            key_d = code_now;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_q       <= 16'd0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_err_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_rdy_q) begin
                if (sr_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (sr_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (!is_shift) begin
                        key_q       <= key_d;
                        key_valid_q <= (key_d != key_q);
                    end
                end
            end
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random scancode streams vs a table model.
module tb_ps2_keyboard;
    localparam int HALF   = 20;
    localparam int TO_CYC = 100;
`ifdef KBD_SHIFT_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        key_valid, frame_err;

    int total = 0, bad = 0;
    int kv_cnt = 0, fe_cnt = 0, kv_bad = 0;
    logic [15:0] prev_key = 16'd0;
    int m_ext = 0, m_brk = 0, m_shift = 0, m_key = 0;
    int hack[int];
    int sym[10] = '{41, 33, 64, 35, 36, 37, 94, 38, 42, 40};

    ps2_keyboard #(.CLK_FREQ_HZ(1_000_000), .TIMEOUT_US(TO_CYC), .FILTER_LEN(8)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Strobe counters; key_valid must coincide exactly with a change of key
    always @(negedge clk) begin
        if (reset_n) begin
            if (key_valid === 1'b1) kv_cnt++;
            if (frame_err === 1'b1) fe_cnt++;
            if ((key !== prev_key) != (key_valid === 1'b1)) kv_bad++;
        end
        prev_key = key;
    end

    task automatic build_map();
        int letters[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43, 'h3B, 'h42, 'h4B, 'h3A,
                            'h31, 'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
        int digits[10]  = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
        int fkeys[12]   = '{'h05, 'h06, 'h04, 'h0C, 'h03, 'h0B, 'h83, 'h0A, 'h01, 'h09, 'h78, 'h07};
        int extk[10]    = '{'h6B, 'h75, 'h74, 'h72, 'h6C, 'h69, 'h7D, 'h7A, 'h70, 'h71};
        for (int i = 0; i < 26; i++) hack[letters[i]] = 65 + i;
        for (int i = 0; i < 10; i++) hack[digits[i]] = 48 + i;
        for (int i = 0; i < 12; i++) hack[fkeys[i]] = 141 + i;
        for (int i = 0; i < 10; i++) hack[256 + extk[i]] = 130 + i;
        hack['h29] = 32; hack['h5A] = 128; hack['h66] = 129; hack['h76] = 140;
    endtask

    function automatic int lookup(int ext, int b, int sh);
        int v;
        if (!hack.exists(ext * 256 + b)) return 0;
        v = hack[ext * 256 + b];
        if (SH_EN && v >= 65 && v <= 90 && sh == 0) v += 32;
        if (SH_EN && v >= 48 && v <= 57 && sh != 0) v = sym[v - 48];
        return v;
    endfunction

    task automatic model_byte(input int b, input bit err);
        int c;
        if (err) begin
            m_ext = 0; m_brk = 0;
        end else if (b == 'hE0) begin
            m_ext = 1;
        end else if (b == 'hF0) begin
            m_brk = 1;
        end else begin
            if (SH_EN && m_ext == 0 && (b == 'h12 || b == 'h59)) begin
                m_shift = (m_brk != 0) ? 0 : 1;
            end else if (m_brk != 0) begin
                if (m_key != 0 && (m_key == lookup(m_ext, b, 0) || m_key == lookup(m_ext, b, 1)))
                    m_key = 0;
            end else begin
                c = lookup(m_ext, b, m_shift);
                if (c != 0) m_key = c;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input int b, input bit badpar);
        logic [7:0] d;
        d = b[7:0];
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ badpar);
        ps2_bit(1'b1);
        repeat (2 * HALF) @(posedge clk);
        #1;
        model_byte(b, badpar);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_ext = 0; m_brk = 0; m_shift = 0; m_key = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (key !== 16'd0) begin bad++; $display("FAIL reset_key: got %0d want 0", key); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        reset_n = 1'b1;
        repeat (4 * HALF) @(posedge clk);
        #1;
        total++; if (fe_cnt != 0) begin bad++; $display("FAIL reset_idle_fe: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_make_break();
        int seq[3] = '{'h1C, 'hF0, 'h1C};
        int kv0, old;
        for (int i = 0; i < 3; i++) begin
            kv0 = kv_cnt; old = m_key;
            send_frame(seq[i], 1'b0);
            total++; if (key !== m_key[15:0]) begin bad++; $display("FAIL mb_key[%0d]: got %0d want %0d", i, key, m_key); end
            total++; if (kv_cnt - kv0 != int'(old != m_key)) begin bad++; $display("FAIL mb_kv[%0d]: got %0d want %0d", i, kv_cnt - kv0, int'(old != m_key)); end
            if (i == 0) begin
                total++; if (key !== (SH_EN ? 16'd97 : 16'd65)) begin bad++; $display("FAIL mb_A: got %0d want %0d", key, SH_EN ? 97 : 65); end
            end
        end
    endtask

    task automatic test_parity();
        int fe0;
        fe0 = fe_cnt;
        send_frame('h1C, 1'b1);
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL par_fe: got %0d want 1", fe_cnt - fe0); end
        total++; if (key !== 16'd0) begin bad++; $display("FAIL par_key: got %0d want 0", key); end
        send_frame('h29, 1'b0);
        total++; if (key !== 16'd32) begin bad++; $display("FAIL par_space: got %0d want 32", key); end
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL par_fe2: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_extended();
        int kv0;
        send_frame('hE0, 1'b0); send_frame('h75, 1'b0);
        total++; if (key !== 16'd131) begin bad++; $display("FAIL ext_up: got %0d want 131", key); end
        send_frame('hE0, 1'b0); send_frame('hF0, 1'b0); send_frame('h75, 1'b0);
        total++; if (key !== 16'd0) begin bad++; $display("FAIL ext_rel: got %0d want 0", key); end
        kv0 = kv_cnt;
        send_frame('h75, 1'b0);
        total++; if (key !== 16'd0) begin bad++; $display("FAIL ext_kp8: got %0d want 0", key); end
        total++; if (kv_cnt != kv0) begin bad++; $display("FAIL ext_kp8_kv: got %0d want 0", kv_cnt - kv0); end
    endtask

    task automatic test_overlap();
        int kv0;
        send_frame('h1C, 1'b0); send_frame('h32, 1'b0);
        total++; if (key !== (SH_EN ? 16'd98 : 16'd66)) begin bad++; $display("FAIL ov_B: got %0d want %0d", key, SH_EN ? 98 : 66); end
        kv0 = kv_cnt;
        send_frame('hF0, 1'b0); send_frame('h1C, 1'b0);
        total++; if (key !== m_key[15:0] || m_key != (SH_EN ? 98 : 66)) begin bad++; $display("FAIL ov_hold: got %0d want %0d", key, SH_EN ? 98 : 66); end
        total++; if (kv_cnt != kv0) begin bad++; $display("FAIL ov_hold_kv: got %0d want 0", kv_cnt - kv0); end
        send_frame('hF0, 1'b0); send_frame('h32, 1'b0);
        total++; if (key !== 16'd0) begin bad++; $display("FAIL ov_rel: got %0d want 0", key); end
        total++; if (kv_cnt - kv0 != 1) begin bad++; $display("FAIL ov_rel_kv: got %0d want 1", kv_cnt - kv0); end
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        #1;
        total++; if (fe_cnt != fe0) begin bad++; $display("FAIL to_early: got %0d want 0", fe_cnt - fe0); end
        repeat (TO_CYC + 3 * HALF) @(posedge clk);
        #1;
        model_byte(0, 1'b1);
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL to_fe: got %0d want 1", fe_cnt - fe0); end
        send_frame('h5A, 1'b0);
        total++; if (key !== 16'd128) begin bad++; $display("FAIL to_enter: got %0d want 128", key); end
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL to_fe2: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_bad_start_glitch();
        int fe0;
        fe0 = fe_cnt;
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
        total++; if (fe_cnt != fe0) begin bad++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - fe0); end
        ps2_bit(1'b1);
        repeat (2 * HALF) @(posedge clk);
        #1;
        model_byte(0, 1'b1);
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL bstart_fe: got %0d want 1", fe_cnt - fe0); end
        total++; if (key !== 16'd128) begin bad++; $display("FAIL bstart_key: got %0d want 128", key); end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        for (int i = 0; i < 4; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        do_reset();
        reset_n = 1'b1;
        fe0 = fe_cnt;
        send_frame('h1C, 1'b0);
        total++; if (fe_cnt != fe0) begin bad++; $display("FAIL mid_fe: got %0d want 0", fe_cnt - fe0); end
        total++; if (key !== (SH_EN ? 16'd97 : 16'd65)) begin bad++; $display("FAIL mid_key: got %0d want %0d", key, SH_EN ? 97 : 65); end
    endtask

    task automatic test_shift();
        int seq[9] = '{'h1C, 'h12, 'h1C, 'hF0, 'h12, 'h12, 'h16, 'hF0, 'h12};
        int kv0, old;
        for (int i = 0; i < 9; i++) begin
            kv0 = kv_cnt; old = m_key;
            send_frame(seq[i], 1'b0);
            total++; if (key !== m_key[15:0]) begin bad++; $display("FAIL sh_key[%0d]: got %0d want %0d", i, key, m_key); end
            total++; if (kv_cnt - kv0 != int'(old != m_key)) begin bad++; $display("FAIL sh_kv[%0d]: got %0d want %0d", i, kv_cnt - kv0, int'(old != m_key)); end
            if (i == 4) begin
                total++; if (key !== 16'd65) begin bad++; $display("FAIL sh_A: got %0d want 65", key); end
            end
        end
        total++; if (key !== (SH_EN ? 16'd33 : 16'd49)) begin bad++; $display("FAIL sh_1: got %0d want %0d", key, SH_EN ? 33 : 49); end
        send_frame('hF0, 1'b0); send_frame('h16, 1'b0);
        total++; if (key !== 16'd0) begin bad++; $display("FAIL sh_rel1: got %0d want 0", key); end
    endtask

    task automatic test_random();
        int pool[16] = '{'h1C, 'h32, 'h45, 'h16, 'h29, 'h5A, 'h75, 'h6B, 'h05, 'h07, 'h12, 'h59, 'h71, 'h66, 'h3E, 'h1A};
        int kv0, fe0, old, b, r;
        bit err;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) b = 'hE0;
            else if (r < 35) b = 'hF0;
            else if (r < 45) b = int'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 15)];
            err = ($urandom_range(0, 9) == 0);
            kv0 = kv_cnt; fe0 = fe_cnt; old = m_key;
            send_frame(b, err);
            total++; if (key !== m_key[15:0]) begin bad++; $display("FAIL rnd_key[%0d] byte %h: got %0d want %0d", i, b, key, m_key); end
            total++; if (kv_cnt - kv0 != int'(old != m_key)) begin bad++; $display("FAIL rnd_kv[%0d]: got %0d want %0d", i, kv_cnt - kv0, int'(old != m_key)); end
            total++; if (fe_cnt - fe0 != int'(err)) begin bad++; $display("FAIL rnd_fe[%0d]: got %0d want %0d", i, fe_cnt - fe0, int'(err)); end
        end
    endtask

    initial begin
        build_map();
        test_reset();
        test_make_break();
        test_parity();
        test_extended();
        test_overlap();
        test_timeout();
        test_bad_start_glitch();
        test_reset_midframe();
        test_shift();
        test_random();
        total++; if (kv_bad != 0) begin bad++; $display("FAIL kv_coincidence: got %0d stray strobes want 0", kv_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
